can_rx_frame_ctrl: RTL
======================

# can_rx_frame_ctrl

Receive-side frame sequencer for the CAN 2.0A controller. It sits between the raw bus input and `can_rx_sample`. It detects bus idle and start-of-frame, then enables the sampler. It consumes the sampler's bit stream, removes stuff bits and parses the standard-format header and data field. At the start of the CRC field it disables the sampler and presents the frame as parallel words with a one-cycle valid strobe.

## Interface
- `CLK_MHZ`, 100, system clock frequency in MHz.
- `BITRATE_KBPS`, 1000, CAN bit rate in kbit/s. Bit period in clocks: `BIT_CLKS = CLK_MHZ*1000/BITRATE_KBPS`, which is 100 at the defaults.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  raw CAN RX line (1 = recessive); already synchronised upstream.
- `smp_en`  out  1  enable to `can_rx_sample`.
- `smp_dout`  in  1  sampled bit from `can_rx_sample`.
- `smp_dvalid`  in  1  one-cycle strobe qualifying `smp_dout`.
- `rx_id`  out  11  received identifier.
- `rx_rtr`  out  1  received RTR bit.
- `rx_dlc`  out  4  received DLC, unclamped.
- `rx_data`  out  64  data bytes, left-justified; byte 0 is in [63:56]; unused bits are 0.
- `rx_valid`  out  1  one-cycle strobe; `rx_*` are valid in this cycle.
- `rx_abort`  out  1  one-cycle strobe; frame dropped (stuff error, SOF not dominant, or IDE=1).

## Operation
- State machine: IDLE_WAIT → IDLE → HDR → DATA → IDLE_WAIT.
- **IDLE_WAIT** (entered after reset, after any frame end or after any abort):
  - Counter `idle_cnt` increments while `din`=1 and clears when `din`=0.
  - The state moves to IDLE when `idle_cnt` reaches `11*BIT_CLKS`.
  - The counter is wide enough for `11*BIT_CLKS` and saturates there.
- **IDLE**: when `din`=0 is seen, `smp_en` is set to 1 registered and the state moves to HDR. All bit and stuff counters clear.
- **Destuffing** applies in HDR and DATA, to every `smp_dvalid` bit:
  - Track the last bit value and a run count of 1 to 5. SOF counts as the first bit of a run.
  - After a run of 5, the next bit is a stuff bit and is discarded. The run count restarts at 1 with the stuff bit's value.
  - If that stuff bit equals the run value, the frame aborts.
- **HDR**: collects 19 destuffed bits in order: SOF, ID[10:0] MSB first, RTR, IDE, r0, DLC[3:0] MSB first.
  - SOF=1 aborts.
  - IDE=1 aborts after the IDE bit.
  - r0 is ignored.
  - Once the DLC is complete: `nbits = RTR ? 0 : 8*min(DLC,8)`.
  - If `nbits`=0, the frame completes; otherwise the state moves to DATA.
- **DATA**: shifts destuffed bits MSB first into a 64-bit shadow register. The frame completes after `nbits` bits.
- **Complete**:
  - `rx_id`, `rx_rtr`, `rx_dlc` and `rx_data` load from the shadow registers.
  - `rx_valid` pulses and `smp_en` drops; the state moves to IDLE_WAIT.
  - Any bits received after this point (CRC and any stuff bit straddling the boundary) are ignored.
- **Abort**: `rx_abort` pulses, `smp_en` drops and the state moves to IDLE_WAIT. The `rx_*` outputs keep their previous frame values.
- `rx_*` outputs hold their values until the next `rx_valid`.

## Timing
- **Reset values**: `smp_en`=0, `rx_id`=0, `rx_rtr`=0, `rx_dlc`=0, `rx_data`=0, `rx_valid`=0, `rx_abort`=0. State is IDLE_WAIT and all counters are 0.
- Asserting reset mid-frame drops `smp_en` asynchronously. No strobe is issued afterwards, and after release 11 idle bit times are needed again.
- `smp_en` rises 1 clock after the first sampled `din`=0 in IDLE.
- `rx_valid` / `rx_abort` assert 1 clock after the `smp_dvalid` that completes or aborts the frame. `smp_en` falls in the same cycle.
- `smp_dvalid` arriving while `smp_en`=0 is ignored.
- `rx_valid` and `rx_abort` are never both 1.
- A `din` low pulse during IDLE_WAIT only restarts the idle count and never starts a frame.

## Test plan
- **Basic frame**: 11 idle bits, then ID=0x123, RTR=0, DLC=2, data 0xA5 0x5A, correctly stuffed → one `rx_valid`; `rx_id`=0x123, `rx_dlc`=2, `rx_data`=0xA55A000000000000. `smp_en` is high from SOF+1 clk until the strobe.
- **Stuffing**: ID=0x000, DLC=0 (the SOF plus ID zeros force stuff bits) → `rx_id`=0, `rx_dlc`=0, `rx_data`=0, `rx_valid` once, no abort.
- **Stuff error**: six consecutive dominant bits starting at SOF → `rx_abort` 1 clk after the 6th `smp_dvalid`, `smp_en` drops, `rx_*` keep the previous frame.
- **RTR and clamping**: RTR=1, DLC=5 → `rx_valid` after 19 bits, `rx_data`=0. Separately, RTR=0, DLC=15 → 64 data bits collected, `rx_dlc`=15.
- **Idle gating**: `din`=0 after only 10 idle bits → `smp_en` stays 0. IDE=1 frame → `rx_abort`.
- **Reset mid-DATA**: assert `rst_n`=0 → all outputs 0 immediately, no strobe; after release the next frame is accepted only after 11 idle bit times.

Source files
------------

// File: rtl/can_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// can_rx_frame_ctrl
//
// Receive-side frame sequencer for a CAN 2.0A controller. It waits for eleven
// recessive bit times of bus idle, then detects the start-of-frame edge and
// enables the bit sampler. It then consumes the sampler's bit stream, removes
// stuff bits, and parses the standard header (SOF, ID, RTR, IDE, r0, DLC) and
// the data field. At the CRC boundary it releases the sampler and presents the
// frame as parallel words with a one-cycle valid strobe. Stuff errors, a
// recessive SOF or an extended-format frame (IDE=1) drop the frame with a
// one-cycle abort strobe instead.
//
// Parameters
//   CLK_MHZ       system clock frequency in MHz
//   BITRATE_KBPS  CAN bit rate in kbit/s
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         raw CAN RX line (1 = recessive), already synchronised
//   smp_en      enable to the bit sampler
//   smp_dout    sampled bit from the sampler
//   smp_dvalid  one-cycle strobe qualifying smp_dout
//   rx_id       received identifier
//   rx_rtr      received RTR bit
//   rx_dlc      received DLC, unclamped
//   rx_data     data bytes, left-justified (byte 0 in [63:56]), unused bits 0
//   rx_valid    one-cycle strobe, rx_* valid in this cycle
//   rx_abort    one-cycle strobe, frame dropped
// -----------------------------------------------------------------------------
module can_rx_frame_ctrl #(
  parameter int CLK_MHZ      = 100,
  parameter int BITRATE_KBPS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic        smp_en,
  input  logic        smp_dout,
  input  logic        smp_dvalid,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        rx_abort
);

  localparam int BIT_CLKS  = CLK_MHZ * 1000 / BITRATE_KBPS;
  localparam int IDLE_CLKS = 11 * BIT_CLKS;
  localparam int IDLE_W    = $clog2(IDLE_CLKS + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CLKS);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  // Destuffed header bit positions (0 = SOF).
  localparam logic [4:0] POS_SOF    = 5'd0;
  localparam logic [4:0] POS_ID_LO  = 5'd1;
  localparam logic [4:0] POS_ID_HI  = 5'd11;
  localparam logic [4:0] POS_RTR    = 5'd12;
  localparam logic [4:0] POS_IDE    = 5'd13;
  localparam logic [4:0] POS_DLC_LO = 5'd15;
  localparam logic [4:0] POS_LAST   = 5'd18;

  typedef enum logic [1:0] {
    IDLE_WAIT,
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t state;
  state_t state_next;

  // Bus idle detection
  logic [IDLE_W-1:0] idle_cnt;

  // Destuffing
  logic       last_bit;
  logic [2:0] run_cnt;      // 0 only before the SOF bit of a frame

  // Header / data collection
  logic [4:0]  hdr_cnt;
  logic [6:0]  data_cnt;
  logic [6:0]  nbits;
  logic [10:0] id_sh;
  logic        rtr_sh;
  logic [3:0]  dlc_sh;
  logic [63:0] data_sh;

  // Per-cycle decode
  logic        bit_in;
  logic        stuff_slot;
  logic        stuff_err;
  logic        bit_take;
  logic        hdr_take;
  logic        hdr_abort;
  logic        hdr_last;
  logic        frame_abort;
  logic        frame_done;
  logic [3:0]  dlc_full;
  logic [6:0]  nbits_calc;
  logic [5:0]  data_idx;
  logic [63:0] data_merged;

  // Registered-output next values
  logic smp_en_next;
  logic valid_next;
  logic abort_next;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples the values present before the clock edge.
    if (!rst_n) state <= IDLE_WAIT;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Bit decode: destuffing, header field positions and frame end conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    // Sampler strobes only count while we own the sampler inside a frame.
    bit_in     = smp_dvalid && smp_en && (state == HDR || state == DATA);
    // After five equal bits the next bit is a stuff bit; it must differ.
    stuff_slot = (run_cnt == 3'd5);
    stuff_err  = bit_in && stuff_slot && (smp_dout == last_bit);
    bit_take   = bit_in && !stuff_slot;
    hdr_take   = bit_take && (state == HDR);

    hdr_abort  = hdr_take && smp_dout &&
                 (hdr_cnt == POS_SOF || hdr_cnt == POS_IDE);
    hdr_last   = hdr_take && (hdr_cnt == POS_LAST);

    // The final DLC bit is still on smp_dout when the header completes.
    dlc_full   = {dlc_sh[2:0], smp_dout};
    if (rtr_sh)           nbits_calc = 7'd0;
    else if (dlc_full[3]) nbits_calc = 7'd64;   // DLC 8..15 all carry 8 bytes
    else                  nbits_calc = {1'b0, dlc_full[2:0], 3'b000};

    // Data is written MSB first from bit 63 down, so the field ends up
    // left-justified without a variable shift at completion.
    data_idx              = ~data_cnt[5:0];
    data_merged           = data_sh;
    data_merged[data_idx] = smp_dout;

    frame_abort = stuff_err || hdr_abort;
    frame_done  = (hdr_last && nbits_calc == 7'd0) ||
                  (bit_take && state == DATA && data_cnt == nbits - 7'd1);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE_WAIT: if (idle_cnt == IDLE_MAX) state_next = IDLE;
      IDLE:      if (!din)                 state_next = HDR;
      HDR: begin
        if (frame_abort || frame_done) state_next = IDLE_WAIT;
        else if (hdr_last)             state_next = DATA;
      end
      DATA:      if (frame_abort || frame_done) state_next = IDLE_WAIT;
      default:   state_next = IDLE_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (values registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    smp_en_next = smp_en;
    case (state)
      IDLE_WAIT: smp_en_next = 1'b0;
      IDLE:      smp_en_next = !din;
      HDR, DATA: if (frame_done || frame_abort) smp_en_next = 1'b0;
      default:   smp_en_next = 1'b0;
    endcase
    // Done and abort cannot coincide; the guard keeps the strobes exclusive
    // regardless.
    valid_next = frame_done && !frame_abort;
    abort_next = frame_abort;
  end

  // ---------------------------------------------------------------------------
  // Idle counter: counts recessive clocks, cleared by any dominant clock and
  // held at zero outside IDLE_WAIT so every re-entry needs a full idle period.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != IDLE_WAIT || !din) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IDLE_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Destuff run tracking. SOF is the first bit of the first run; a stuff bit
  // starts a new run of its own value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bit <= 1'b0;
      run_cnt  <= 3'd0;
    end else if (state == IDLE) begin
      last_bit <= 1'b0;
      run_cnt  <= 3'd0;
    end else if (bit_in) begin
      if (stuff_slot || run_cnt == 3'd0 || smp_dout != last_bit) begin
        last_bit <= smp_dout;
        run_cnt  <= 3'd1;
      end else begin
        run_cnt  <= run_cnt + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Header and data shadow registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt  <= '0;
      data_cnt <= '0;
      nbits    <= '0;
      id_sh    <= '0;
      rtr_sh   <= 1'b0;
      dlc_sh   <= '0;
      data_sh  <= '0;
    end else if (state == IDLE) begin
      hdr_cnt  <= '0;
      data_cnt <= '0;
      nbits    <= '0;
      id_sh    <= '0;
      rtr_sh   <= 1'b0;
      dlc_sh   <= '0;
      data_sh  <= '0;
    end else if (bit_take) begin
      if (state == HDR) begin
        hdr_cnt <= hdr_cnt + 5'd1;
        if (hdr_cnt >= POS_ID_LO && hdr_cnt <= POS_ID_HI) id_sh <= {id_sh[9:0], smp_dout};
        if (hdr_cnt == POS_RTR)    rtr_sh <= smp_dout;
        if (hdr_cnt >= POS_DLC_LO) dlc_sh <= dlc_full;
        if (hdr_cnt == POS_LAST)   nbits  <= nbits_calc;
      end else begin
        data_sh  <= data_merged;
        data_cnt <= data_cnt + 7'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. rx_* only change on a completed frame, so an abort
  // leaves the previous frame visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_en   <= 1'b0;
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      rx_id    <= '0;
      rx_rtr   <= 1'b0;
      rx_dlc   <= '0;
      rx_data  <= '0;
    end else begin
      smp_en   <= smp_en_next;
      rx_valid <= valid_next;
      rx_abort <= abort_next;
      if (valid_next) begin
        rx_id   <= id_sh;
        rx_rtr  <= rtr_sh;
        // The completing bit has not reached the shadows yet.
        rx_dlc  <= (state == HDR)  ? dlc_full    : dlc_sh;
        rx_data <= (state == DATA) ? data_merged : data_sh;
      end
    end
  end

endmodule
